// File: rtl/rr_sched_w512.sv
// Round-robin scheduler around a registered 512-way programmable priority encoder.
// Define RR_SCHED_ROUND_ROBIN_EN for round-robin pointer advance; otherwise fixed priority (pointer held at 0).
module rr_sched_w512 #(
    parameter int unsigned W  = 512,
    parameter int unsigned IW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_vld,
    input  logic [IW-1:0] set_idx,
    input  logic          flush,
    output logic [W-1:0]  ppe_req,
    output logic [IW-1:0] ppe_ptr,
    input  logic [IW-1:0] ppe_value,
    input  logic          ppe_valid,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx,
    input  logic          gnt_ready,
    output logic [IW:0]   pend_cnt
);

    localparam int unsigned CW = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_OFFER
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  req_q, req_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          gnt_vld_q, gnt_vld_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hs;
    logic          same_set;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_q     <= '0;
            ptr_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_idx_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            ptr_q     <= ptr_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_idx_q <= gnt_idx_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state, bitmap, counter and pointer update
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        ptr_d     = ptr_q;
        gnt_vld_d = gnt_vld_q;
        gnt_idx_d = gnt_idx_q;
        cnt_d     = cnt_q;
        hs        = gnt_vld_q & gnt_ready;
        same_set  = set_vld & (set_idx == gnt_idx_q);

        if (flush) begin
            // Flush clears first, then a same-cycle set lands on the empty bitmap
            req_d          = '0;
            req_d[set_idx] = set_vld;
            cnt_d          = CW'(set_vld);
            gnt_vld_d      = 1'b0;
            state_d        = S_IDLE;
        end else begin
            if (hs) begin
                req_d[gnt_idx_q] = 1'b0;
            end
            if (set_vld) begin
                req_d[set_idx] = 1'b1;
            end
            cnt_d = cnt_q + CW'(set_vld & ~req_q[set_idx]) - CW'(hs & ~same_set);

            case (state_q)
                S_IDLE: begin
                    if (|req_q) begin
                        state_d = S_LAUNCH;
                    end
                end
                S_LAUNCH: state_d = S_WAIT;
                S_WAIT:   state_d = S_CAPTURE;
                S_CAPTURE: begin
                    if (ppe_valid) begin
                        gnt_idx_d = ppe_value;
                        gnt_vld_d = 1'b1;
                        state_d   = S_OFFER;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end
                S_OFFER: begin
                    if (hs) begin
                        gnt_vld_d = 1'b0;
`ifdef RR_SCHED_ROUND_ROBIN_EN
                        ptr_d     = gnt_idx_q + IW'(1);
`else
                        ptr_d     = '0;
`endif
                        state_d   = (|req_d) ? S_LAUNCH : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign ppe_req   = req_q;
    assign ppe_ptr   = ptr_q;
    assign gnt_valid = gnt_vld_q;
    assign gnt_idx   = gnt_idx_q;
    assign pend_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_sched_w512.sv
// Bench for rr_sched_w512: encoder stand-in, timeline-level reference model, directed and random stimulus.
module tb_rr_sched_w512;

`ifdef RR_SCHED_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         set_vld = 1'b0;
    logic [8:0]   set_idx = '0;
    logic         flush = 1'b0;
    logic [511:0] ppe_req;
    logic [8:0]   ppe_ptr;
    logic [8:0]   ppe_value = '0;
    logic         ppe_valid = 1'b0;
    logic         gnt_valid;
    logic [8:0]   gnt_idx;
    logic         gnt_ready = 1'b0;
    logic [9:0]   pend_cnt;

    int checks = 0;
    int errors = 0;

    rr_sched_w512 dut (
        .clk(clk), .rst(rst), .set_vld(set_vld), .set_idx(set_idx), .flush(flush),
        .ppe_req(ppe_req), .ppe_ptr(ppe_ptr), .ppe_value(ppe_value), .ppe_valid(ppe_valid),
        .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_ready(gnt_ready), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    // First pending index at or after p, wrapping; -1 if none
    function automatic int first_from(input logic [511:0] b, input int p);
        for (int k = 0; k < 512; k++) begin
            if (b[(p + k) % 512]) return (p + k) % 512;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Two-register encoder stand-in: input sample, then result register
    logic [511:0] s1_req = '0;
    logic [8:0]   s1_ptr = '0;
    always @(posedge clk) begin
        s1_req    <= ppe_req;
        s1_ptr    <= ppe_ptr;
        ppe_valid <= |s1_req;
        ppe_value <= (|s1_req) ? 9'(first_from(s1_req, int'(s1_ptr))) : 9'd0;
    end

    // Reference model: pending set, pointer, round timeline, offered grant
    logic [511:0] m_bits = '0;
    logic [511:0] nb;
    int           m_ptr = 0;
    bit           m_round = 1'b0;
    int           m_t = 0;
    int           m_win = -1;
    bit           m_offer = 1'b0;
    logic [8:0]   m_gidx = '0;
    bit           m_hs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bits = '0; m_ptr = 0; m_round = 1'b0; m_t = 0; m_offer = 1'b0; m_gidx = '0;
        end else begin
            m_hs = 1'b0;
            nb   = m_bits;
            if (flush) begin
                nb = '0; m_round = 1'b0; m_offer = 1'b0;
            end else if (m_offer) begin
                if (gnt_ready) begin
                    m_hs = 1'b1;
                    nb[m_gidx] = 1'b0;
                    m_ptr = RR ? (int'(m_gidx) + 1) % 512 : 0;
                    m_offer = 1'b0;
                end
            end else if (m_round) begin
                if (m_t == 0) m_win = first_from(m_bits, m_ptr);
                if (m_t == 2) begin
                    m_round = 1'b0;
                    if (m_win >= 0) begin
                        m_offer = 1'b1;
                        m_gidx  = 9'(m_win);
                    end
                end else begin
                    m_t++;
                end
            end else if (m_bits != '0) begin
                m_round = 1'b1; m_t = 0;
            end
            if (set_vld) nb[set_idx] = 1'b1;
            if (m_hs && nb != '0) begin
                m_round = 1'b1; m_t = 0;
            end
            m_bits = nb;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_ppe_req", ppe_req, m_bits);
            chk("m_ppe_ptr", 512'(ppe_ptr), 512'(m_ptr));
            chk("m_gnt_valid", 512'(gnt_valid), 512'(m_offer));
            if (m_offer) chk("m_gnt_idx", 512'(gnt_idx), 512'(m_gidx));
            chk("m_pend_cnt", 512'(pend_cnt), 512'($countones(m_bits)));
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    // Advance until gnt_valid is seen; returns at that negedge
    task automatic wait_grant(input string nm, output logic [8:0] idx);
        idx = '0;
        for (int i = 0; i < 40; i++) begin
            if (gnt_valid) begin
                idx = gnt_idx;
                return;
            end
            nxt();
        end
        chk({nm, "_timeout"}, 512'(gnt_valid), 512'(1));
    endtask

    logic [8:0]   g;
    logic [8:0]   gq[$];
    int           cq[$];
    logic [511:0] e;

    initial begin
        repeat (3) nxt();
        chk("rst_req", ppe_req, '0);
        chk("rst_ptr", 512'(ppe_ptr), 512'(0));
        chk("rst_gvalid", 512'(gnt_valid), 512'(0));
        chk("rst_gidx", 512'(gnt_idx), 512'(0));
        chk("rst_cnt", 512'(pend_cnt), 512'(0));
        rst = 1'b0;
        nxt();

        // Set-to-grant latency
        set_vld = 1'b1; set_idx = 9'd7; nxt();
        set_vld = 1'b0; repeat (3) nxt();
        chk("t1_c4_gvalid", 512'(gnt_valid), 512'(0));
        chk("t1_c4_cnt", 512'(pend_cnt), 512'(1));
        nxt();
        chk("t1_c5_gvalid", 512'(gnt_valid), 512'(1));
        chk("t1_c5_gidx", 512'(gnt_idx), 512'(7));
        gnt_ready = 1'b1; nxt();
        gnt_ready = 1'b0;
        chk("t1_c6_gvalid", 512'(gnt_valid), 512'(0));
        chk("t1_c6_cnt", 512'(pend_cnt), 512'(0));
        repeat (6) nxt();
        chk("t1_idle_gvalid", 512'(gnt_valid), 512'(0));

        // Back-to-back grants with wrap of the pointer
        gnt_ready = 1'b1;
        set_vld = 1'b1; set_idx = 9'd3;   nxt();
        set_idx = 9'd200;                 nxt();
        set_idx = 9'd511;                 nxt();
        set_vld = 1'b0;
        for (int c = 3; c < 23; c++) begin
            if (gnt_valid) begin
                gq.push_back(gnt_idx);
                cq.push_back(c);
            end
            nxt();
        end
        chk("t2_count", 512'(gq.size()), 512'(3));
        if (gq.size() == 3) begin
            chk("t2_g0", 512'(gq[0]), 512'(3));
            chk("t2_g1", 512'(gq[1]), 512'(200));
            chk("t2_g2", 512'(gq[2]), 512'(511));
            chk("t2_c0", 512'(cq[0]), 512'(5));
            chk("t2_c1", 512'(cq[1]), 512'(9));
            chk("t2_c2", 512'(cq[2]), 512'(13));
        end
        chk("t2_ptr_wrap", 512'(ppe_ptr), 512'(0));
        set_vld = 1'b1; set_idx = 9'd0; nxt();
        set_vld = 1'b0;
        wait_grant("t2_g3", g);
        chk("t2_g3", 512'(g), 512'(0));
        nxt();
        gnt_ready = 1'b0;
        nxt();
        chk("t2_ptr_after0", 512'(ppe_ptr), 512'(RR ? 1 : 0));

        // Re-set of the granted index in the handshake cycle
        set_vld = 1'b1; set_idx = 9'd5;  nxt();
        set_idx = 9'd10;                 nxt();
        set_vld = 1'b0;
        wait_grant("t3_g0", g);
        chk("t3_g0", 512'(g), 512'(5));
        chk("t3_cnt_before", 512'(pend_cnt), 512'(2));
        gnt_ready = 1'b1; set_vld = 1'b1; set_idx = 9'd5; nxt();
        set_vld = 1'b0;
        chk("t3_cnt_same", 512'(pend_cnt), 512'(2));
        chk("t3_bit5_kept", 512'(ppe_req[5]), 512'(1));
        wait_grant("t3_g1", g);
        chk("t3_g1", 512'(g), 512'(RR ? 10 : 5));
        nxt();
        wait_grant("t3_g2", g);
        chk("t3_g2", 512'(g), 512'(RR ? 5 : 10));
        nxt();
        gnt_ready = 1'b0;
        repeat (3) nxt();

        // Backpressure: grant held stable, new set counted
        set_vld = 1'b1; set_idx = 9'd42; nxt();
        set_vld = 1'b0;
        wait_grant("t4_g0", g);
        chk("t4_g0", 512'(g), 512'(42));
        for (int i = 0; i < 20; i++) begin
            chk("t4_hold_valid", 512'(gnt_valid), 512'(1));
            chk("t4_hold_idx", 512'(gnt_idx), 512'(42));
            if (i == 0)  chk("t4_cnt0", 512'(pend_cnt), 512'(1));
            if (i == 11) chk("t4_cnt1", 512'(pend_cnt), 512'(2));
            set_vld = (i == 10);
            set_idx = 9'd300;
            nxt();
        end
        set_vld = 1'b0;
        gnt_ready = 1'b1; nxt();
        gnt_ready = 1'b0;
        wait_grant("t4_g1", g);
        chk("t4_g1", 512'(g), 512'(300));
        gnt_ready = 1'b1; nxt();
        gnt_ready = 1'b0;
        repeat (3) nxt();

        // Flush during the encoder wait, with a same-cycle set
        set_vld = 1'b1; set_idx = 9'd1; nxt();
        set_idx = 9'd2;                 nxt();
        set_idx = 9'd3;                 nxt();
        flush = 1'b1; set_idx = 9'd9;   nxt();
        flush = 1'b0; set_vld = 1'b0;
        e = '0; e[9] = 1'b1;
        chk("t5_req", ppe_req, e);
        chk("t5_cnt", 512'(pend_cnt), 512'(1));
        chk("t5_gvalid", 512'(gnt_valid), 512'(0));
        wait_grant("t5_g0", g);
        chk("t5_g0", 512'(g), 512'(9));
        gnt_ready = 1'b1; nxt();
        gnt_ready = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst       = 1'b0;
            set_vld   = ($urandom_range(0, 2) == 0);
            set_idx   = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
            if (gnt_valid && $urandom_range(0, 3) == 0) set_idx = gnt_idx;
            gnt_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                #1;
                chk("rnd_rst_req", ppe_req, '0);
                chk("rnd_rst_gvalid", 512'(gnt_valid), 512'(0));
                chk("rnd_rst_cnt", 512'(pend_cnt), 512'(0));
            end
            nxt();
        end
        rst = 1'b0; set_vld = 1'b0; flush = 1'b0; gnt_ready = 1'b0;
        repeat (5) nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
